// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends start, port, length and payload bits as one frame on a single wire
module serial_frame_tx #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clkEn,
   input  logic              start,
   input  logic [PORT_W-1:0] port_num,
   input  logic [LEN_W-1:0]  data_len,
   input  logic [DATA_W-1:0] data_in,
   output logic              SerOut,
   output logic              ready,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, DONE} state_t;

   localparam logic [3:0]       PORT_END = 4'(PORT_W - 1);
   localparam logic [3:0]       LEN_END  = 4'(LEN_W - 1);
   localparam logic [LEN_W-1:0] DMAX     = LEN_W'(DATA_W);

   state_t            state;
   logic [3:0]        cnt;
   logic [PORT_W-1:0] port_sr;
   logic [LEN_W-1:0]  len_sr;
   logic [LEN_W-1:0]  len_q;
   logic [DATA_W-1:0] data_sr;

   // Frame FSM: payload is left-aligned at accept so every field shifts out of its MSB
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         port_sr <= '0;
         len_sr  <= '0;
         len_q   <= '0;
         data_sr <= '0;
         SerOut  <= 1'b1;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (clkEn) begin
         if (ready && start) begin
            state   <= START;
            cnt     <= '0;
            port_sr <= port_num;
            len_sr  <= data_len;
            len_q   <= data_len;
            data_sr <= data_in << (DMAX - data_len);
            SerOut  <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
         end else begin
            case (state)
               START: begin
                  state   <= PORT;
                  cnt     <= '0;
                  SerOut  <= port_sr[PORT_W-1];
                  port_sr <= port_sr << 1;
               end
               PORT: begin
                  if (cnt == PORT_END) begin
                     state  <= LEN;
                     cnt    <= '0;
                     SerOut <= len_sr[LEN_W-1];
                     len_sr <= len_sr << 1;
                  end else begin
                     cnt     <= cnt + 4'd1;
                     SerOut  <= port_sr[PORT_W-1];
                     port_sr <= port_sr << 1;
                  end
               end
               LEN: begin
                  if (cnt == LEN_END && len_q != '0) begin
                     state   <= DATA;
                     cnt     <= '0;
                     SerOut  <= data_sr[DATA_W-1];
                     data_sr <= data_sr << 1;
                  end else if (cnt == LEN_END) begin
                     state  <= DONE;
                     SerOut <= 1'b1;
                     ready  <= 1'b1;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     cnt    <= cnt + 4'd1;
                     SerOut <= len_sr[LEN_W-1];
                     len_sr <= len_sr << 1;
                  end
               end
               DATA: begin
                  if (cnt == 4'(len_q - 1'b1)) begin
                     state  <= DONE;
                     SerOut <= 1'b1;
                     ready  <= 1'b1;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     cnt     <= cnt + 4'd1;
                     SerOut  <= data_sr[DATA_W-1];
                     data_sr <= data_sr << 1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  SerOut <= 1'b1;
                  ready  <= 1'b1;
                  busy   <= 1'b0;
                  done   <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed and randomized frames checked against a queue-built expected bit stream
module tb_serial_frame_tx;
   logic        clk = 1'b0;
   logic        rst, clkEn, start;
   logic [1:0]  port_num;
   logic [3:0]  data_len;
   logic [14:0] data_in;
   logic        SerOut, ready, busy, done;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          exp_q[$];

   serial_frame_tx dut (
      .clk(clk), .rst(rst), .clkEn(clkEn), .start(start),
      .port_num(port_num), .data_len(data_len), .data_in(data_in),
      .SerOut(SerOut), .ready(ready), .busy(busy), .done(done)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   task automatic step(input logic en);
      clkEn = en;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ser"}, SerOut, 1);
      chk({tag, "_ready"}, ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic scramble();
      port_num = 2'($urandom);
      data_len = 4'($urandom);
      data_in  = 15'($urandom);
   endtask

   // Expected line: start 0, port MSB-first, length MSB-first, payload[N-1:0] MSB-first, then the done bit
   task automatic build(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 1; i >= 0; i--) exp_q.push_back(p[i]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(l[i]);
      for (int i = int'(l) - 1; i >= 0; i--) exp_q.push_back(d[i]);
      exp_q.push_back(1'b1);
   endtask

   task automatic send(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                       input int stall, input bit iso, input bit chain);
      int n;
      build(p, l, d);
      n = exp_q.size();
      port_num = p;
      data_len = l;
      data_in  = d;
      start    = 1'b1;
      step(1'b1);
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         chk("ser", SerOut, exp_q[k]);
         chk("busy", busy, k < n - 1);
         chk("done", done, k == n - 1);
         chk("ready", ready, k == n - 1);
         if (k == n - 1) break;
         for (int s = 1; s < stall; s++) begin
            if (iso) begin
               scramble();
               start = 1'($urandom);
            end
            step(1'b0);
            chk("hold_ser", SerOut, exp_q[k]);
            chk("hold_busy", busy, 1);
         end
         if (iso) begin
            scramble();
            start = 1'($urandom);
         end
         step(1'b1);
      end
      if (!chain) begin
         if (iso) scramble();
         start = 1'b0;
         step(1'b1);
         chk_idle("after");
      end
   endtask

   initial begin
      rst = 1'b1; clkEn = 1'b0; start = 1'b0;
      port_num = '0; data_len = '0; data_in = '0;
      step(1'b1);
      step(1'b0);
      chk_idle("reset");
      rst = 1'b0;
      start = 1'b1;
      step(1'b0);
      chk_idle("noen");
      start = 1'b0;
      step(1'b1);
      chk_idle("idle");

      send(2'b10, 4'd3, 15'b101, 1, 0, 0);
      send(2'b01, 4'd0, 15'h7fff, 1, 0, 0);
      send(2'b11, 4'd15, 15'h5555, 4, 0, 0);
      send(2'b01, 4'd2, 15'b10, 1, 0, 1);
      send(2'b10, 4'd5, 15'h13, 1, 0, 1);
      send(2'b00, 4'd0, 15'h0, 2, 0, 0);
      send(2'b10, 4'd9, 15'h2a5, 3, 1, 0);

      build(2'b11, 4'd6, 15'h2d);
      port_num = 2'b11; data_len = 4'd6; data_in = 15'h2d; start = 1'b1;
      step(1'b1);
      start = 1'b0;
      for (int k = 1; k <= 4; k++) step(1'b1);
      chk("pre_rst_ser", SerOut, exp_q[4]);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      step(1'b1);
      chk_idle("midrst");
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step(1'b1);
         chk("post_rst_done", done, 0);
      end
      send(2'b01, 4'd4, 15'b1001, 1, 0, 0);

      for (int f = 0; f < 24; f++)
         send(2'($urandom), 4'($urandom), 15'($urandom), int'($urandom_range(1, 3)),
              1'($urandom), (f < 23) ? 1'($urandom) : 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter for the lab's single-wire port-addressed link. It accepts a port number, a payload length and a payload over a parallel start/ready handshake. It then drives them onto `SerOut` as one frame, one bit per `clkEn` tick: start bit, 2-bit port, 4-bit length, N payload bits, and a one-tick done/stop phase. It sits on the sending side of the link and produces exactly the frame format the serial receiving controller decodes.

## Interface
- `PORT_W`, 2: width of port-number field.
- `LEN_W`, 4: width of length field; max payload = 2^LEN_W − 1 bits.
- `DATA_W`, 15: payload register width (= 2^LEN_W − 1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clkEn`  in  1  bit-rate tick; state, counters and shifters advance only on edges with `clkEn`=1.
- `start`  in  1  frame request, level; held until accepted.
- `port_num`  in  PORT_W  destination port, captured at accept.
- `data_len`  in  LEN_W  payload bit count N (0..15), captured at accept.
- `data_in`  in  DATA_W  payload; bits [N−1:0] sent, captured at accept.
- `SerOut`  out  1  serial line; idles high.
- `ready`  out  1  high in IDLE and DONE; accept possible.
- `busy`  out  1  high in START, PORT, LEN, DATA.
- `done`  out  1  high for the whole DONE state (one tick period).

## Operation
- States: IDLE, START, PORT, LEN, DATA, DONE (3-bit encoding).
- Accept = `ready` & `start` & `clkEn` at a rising edge. On accept: latch `port_num`, `data_len`, `data_in` into internal shift/length registers, clear bit counter, go to START.
- Transitions (on `clkEn` edges only):
  - IDLE → START on accept; else stay.
  - START → PORT.
  - PORT → LEN after PORT_W ticks.
  - LEN → DATA after LEN_W ticks if latched N ≠ 0; → DONE if N = 0.
  - DATA → DONE after N ticks.
  - DONE → START on accept (back-to-back); else → IDLE.
- `SerOut` by state:
  - IDLE = 1, START = 0, DONE = 1.
  - PORT: port bits MSB-first.
  - LEN: length bits MSB-first.
  - DATA: `data_in[N−1]` first down to `data_in[0]`.
- Bit counter 4 bits, reset to 0 on every field entry; field end when counter = field width − 1 on a `clkEn` edge.
- Inputs are ignored after accept; changes mid-frame have no effect on the frame in flight.
- `start` with `clkEn`=0 is not accepted; `start` outside `ready` is ignored (not queued).

## Timing
- All outputs are Moore: functions of registered state and shift registers, with no combinational path from inputs.
- Each bit of `SerOut` lasts exactly one `clkEn` period. `SerOut` changes only on `clkEn` edges.
- Frame length from accept edge = 1 + PORT_W + LEN_W + N ticks of `busy`, followed by 1 tick of `done`. Nominal sizes: 7 + N busy ticks, then 1 done tick.
- `ready` falls on the edge after accept; it rises again on the edge entering DONE.
- `clkEn` low for any number of cycles freezes state, counters and `SerOut`.
- Reset (`rst`=1 at a rising edge, priority over `clkEn` and `start`):
  - State returns to IDLE.
  - `SerOut`=1, `ready`=1, `busy`=0, `done`=0.
  - Counters and latched registers are cleared to 0.
- Reset mid-frame aborts the frame immediately. The line returns high on the next edge and no `done` is produced.

## Test plan
- Basic frame: port=2'b10, len=3, data=3'b101, single-cycle accept. Required `SerOut` per tick is 0 \| 1 0 \| 0 0 1 1 \| 1 0 1, then 1 with `done`=1, then 1 idle. `busy` lasts 10 ticks.
- Zero length: port=2'b01, len=0. Required `SerOut` is 0 \| 0 1 \| 0 0 0 0, then DONE (1, `done`=1). No DATA state is visited.
- Max length with stall: len=15, data=15'h5555, `clkEn` asserted every 4th cycle. Required `SerOut` is 0 \| port \| 1111 \| 1 0 1 0 … 1 (15 bits), and each bit is held exactly 4 clk cycles.
- Back-to-back: `start` held high. During DONE, `ready`=1 and accept occurs on the DONE tick. The next tick is START (`SerOut`=0) with no IDLE gap.
- Reset mid-frame: assert `rst` during LEN. On the next edge, `SerOut`=1, `ready`=1, `busy`=0 and `done` never pulses. A new accept then produces a complete, correct frame.
- Input isolation: change `port_num`/`data_in` every cycle after accept. The transmitted frame must equal the values captured at accept; `start` pulses with `clkEn`=0 must be ignored.
